// File: rtl/axis_spi_slave_cfg.sv
// SPI slave with configurable word width, CPOL/CPHA and bit order, oversampled in the aclk domain.
// Received words leave on an AXI4-Stream master port; transmit words are pulled from an AXIS slave port.
module axis_spi_slave_cfg #(
  parameter int C_DATA_WIDTH  = 8,
  parameter int C_CPOL        = 0,
  parameter int C_CPHA        = 1,
  parameter int C_MSB_FIRST   = 1,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    SS_I,
  output logic                    SS_O,
  output logic                    SS_T,
  input  logic                    SCK_I,
  output logic                    SCK_O,
  output logic                    SCK_T,
  input  logic                    IO0_I,
  output logic                    IO0_O,
  output logic                    IO0_T,
  output logic                    IO1_O,
  output logic                    IO1_T,
  output logic [C_DATA_WIDTH-1:0] axis_rx_tdata,
  output logic                    axis_rx_tvalid,
  input  logic                    axis_rx_tready,
  input  logic [C_DATA_WIDTH-1:0] axis_tx_tdata,
  input  logic                    axis_tx_tvalid,
  output logic                    axis_tx_tready,
  output logic                    frame_active,
  output logic                    rx_overflow,
  output logic                    tx_underrun,
  output logic                    frame_abort
);

  localparam int W  = C_DATA_WIDTH;
  localparam int S  = C_SYNC_STAGES;
  localparam int CW = $clog2(C_DATA_WIDTH);
  localparam logic          SCK_IDLE = (C_CPOL != 0);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic [S-1:0]  ss_sync, sck_sync, mosi_sync, flush;
  logic          sck_prev, blocked, sel_prev;
  logic [CW-1:0] bit_cnt;
  logic [W-1:0]  rx_shift, tx_shift, rx_next, tx_next;
  logic          ss_s, sck_s, mosi_s, sel, frame_start, frame_end;
  logic          lead_edge, trail_edge, sample_edge, shift_edge;
  logic          word_done, rx_free, tx_load;

  assign SS_O  = 1'b1;
  assign SS_T  = 1'b1;
  assign SCK_O = 1'b0;
  assign SCK_T = 1'b1;
  assign IO0_O = 1'b0;
  assign IO0_T = 1'b1;

  // NOTE: chains are preset to the idle bus levels (SS high, SCK at CPOL) so leaving reset
  // never fabricates an SS or SCK edge. flush marks when the chains hold real samples again.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ss_sync   <= '1;
      sck_sync  <= {S{SCK_IDLE}};
      mosi_sync <= '0;
      flush     <= '0;
      sck_prev  <= SCK_IDLE;
      blocked   <= 1'b1;
      sel_prev  <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[S-2:0], SS_I};
      sck_sync  <= {sck_sync[S-2:0], SCK_I};
      mosi_sync <= {mosi_sync[S-2:0], IO0_I};
      flush     <= {flush[S-2:0], 1'b1};
      sck_prev  <= sck_sync[S-1];
      sel_prev  <= sel;
      // A frame cut by reset stays ignored until SS has genuinely been seen high.
      if (flush[S-1] && ss_sync[S-1]) blocked <= 1'b0;
    end
  end

  assign ss_s        = ss_sync[S-1];
  assign sck_s       = sck_sync[S-1];
  assign mosi_s      = mosi_sync[S-1];
  assign sel         = !ss_s && !blocked;
  assign frame_start = sel && !sel_prev;
  assign frame_end   = !sel && sel_prev;

  assign lead_edge   = sel && (sck_prev == SCK_IDLE) && (sck_s != SCK_IDLE);
  assign trail_edge  = sel && (sck_prev != SCK_IDLE) && (sck_s == SCK_IDLE);
  assign sample_edge = (C_CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (C_CPHA != 0) ? lead_edge : trail_edge;

  assign rx_next = (C_MSB_FIRST != 0) ? {rx_shift[W-2:0], mosi_s} : {mosi_s, rx_shift[W-1:1]};
  assign tx_next = (C_MSB_FIRST != 0) ? {tx_shift[W-2:0], 1'b0} : {1'b0, tx_shift[W-1:1]};

  assign word_done = sample_edge && (bit_cnt == LAST_BIT);
  assign rx_free   = !axis_rx_tvalid || axis_rx_tready;
  // bit_cnt is 0 on a shift edge only before a word's first bit (CPHA=1) or right after a
  // word completes (CPHA=0); CPHA=0 also needs the first word ready at SS assert.
  assign tx_load   = (shift_edge && (bit_cnt == '0)) || ((C_CPHA == 0) && frame_start);

  assign axis_tx_tready = tx_load && axis_tx_tvalid;
  assign IO1_O          = (C_MSB_FIRST != 0) ? tx_shift[W-1] : tx_shift[0];
  assign IO1_T          = !frame_active;
  assign frame_active   = sel_prev;

  // NOTE: all state here is updated with non-blocking assignments so every branch reads the
  // pre-edge values; a later assignment to the same register intentionally overrides an earlier one.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      axis_rx_tdata  <= '0;
      axis_rx_tvalid <= 1'b0;
      rx_overflow    <= 1'b0;
      tx_underrun    <= 1'b0;
      frame_abort    <= 1'b0;
    end else begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      if (axis_rx_tvalid && axis_rx_tready) axis_rx_tvalid <= 1'b0;

      if (frame_end) begin
        bit_cnt     <= '0;
        rx_shift    <= '0;
        frame_abort <= (bit_cnt != '0);
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
        if (word_done) begin
          if (rx_free) begin
            axis_rx_tdata  <= rx_next;
            axis_rx_tvalid <= 1'b1;
          end else begin
            rx_overflow <= 1'b1;
          end
        end
      end

      if (tx_load) begin
        tx_shift    <= axis_tx_tvalid ? axis_tx_tdata : '0;
        tx_underrun <= !axis_tx_tvalid;
      end else if (shift_edge) begin
        tx_shift <= tx_next;
      end
    end
  end

endmodule
